pwm_3l_modulator: RTL

PWM_3L_MODULATOR -- requirements
Module: pwm_3l_modulator

---
 rtl/pwm_3l_modulator_pkg.sv | 18 +
 rtl/pwm_3l_modulator_if.sv | 38 +++
 rtl/pwm_deadtime_leg.sv | 91 +++++++++
 rtl/pwm_3l_modulator.sv | 76 +++++++
 4 files changed

// File: rtl/pwm_3l_modulator_pkg.sv
// Shared definitions for the three-level PWM modulator.
//   - leg_state_e  : per-leg gate FSM state (2-bit encoding)
//   - DeadCntWidth : width of the dead-time down-counter (DeadCycles up to 255)
//   - DefaultWidth / DefaultDeadCycles : default parameter values
package pwm_3l_modulator_pkg;

    localparam int unsigned DefaultWidth      = 7;
    localparam int unsigned DefaultDeadCycles = 4;
    localparam int unsigned DeadCntWidth      = 8;

    typedef enum logic [1:0] {
        StOff  = 2'b00,
        StLo   = 2'b01,
        StDead = 2'b10,
        StHi   = 2'b11
    } leg_state_e;

endpackage

// File: rtl/pwm_3l_modulator_if.sv
// Signal bundle for driving and observing pwm_3l_modulator.
//   clk_i      : clock (interface port)
//   rst        : synchronous active-high reset
//   enable     : modulator run enable
//   duty       : modulation reference
//   carrier0   : 0-degree triangular carrier (cell 1)
//   carrier180 : 180-degree triangular carrier (cell 2)
//   gate*_hi/lo: complementary gate pairs of cells 1 and 2
// master drives the reference/carriers and observes gates; slave is the modulator side.
interface pwm_3l_modulator_if #(
    parameter int unsigned Width = pwm_3l_modulator_pkg::DefaultWidth
) (
    input logic clk_i
);

    logic             rst;
    logic             enable;
    logic [Width-1:0] duty;
    logic [Width-1:0] carrier0;
    logic [Width-1:0] carrier180;
    logic             gate1_hi;
    logic             gate1_lo;
    logic             gate2_hi;
    logic             gate2_lo;

    modport master (
        input  clk_i,
        output rst, enable, duty, carrier0, carrier180,
        input  gate1_hi, gate1_lo, gate2_hi, gate2_lo
    );

    modport slave (
        input  clk_i,
        input  rst, enable, duty, carrier0, carrier180,
        output gate1_hi, gate1_lo, gate2_hi, gate2_lo
    );

endinterface

// File: rtl/pwm_deadtime_leg.sv
// One half-bridge leg: gate FSM with dead-time insertion.
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset (to OFF, counter cleared, gates low)
//   enable_i : 0 forces OFF on the next edge
//   raw_i    : requested side (1 = hi, 0 = lo), combinational compare result
//   hi_o     : registered hi gate
//   lo_o     : registered lo gate
// Every change of side, and every start from OFF, passes through DeadCycles cycles of
// both gates low. Gates are decoded from the next state and registered, so a gate
// always reflects the state held in the same cycle.
module pwm_deadtime_leg
    import pwm_3l_modulator_pkg::*;
#(
    parameter int unsigned DeadCycles = DefaultDeadCycles
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable_i,
    input  logic raw_i,
    output logic hi_o,
    output logic lo_o
);

    localparam logic [DeadCntWidth-1:0] DeadLoad = DeadCntWidth'(DeadCycles - 1);
    localparam logic [DeadCntWidth-1:0] CntOne   = DeadCntWidth'(1);

    leg_state_e              state_q, state_d;
    logic [DeadCntWidth-1:0] cnt_q, cnt_d;
    logic                    hi_q, hi_d;
    logic                    lo_q, lo_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!enable_i) begin
            state_d = StOff;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StOff: begin
                    state_d = StDead;
                    cnt_d   = DeadLoad;
                end
                StLo: begin
                    if (raw_i) begin
                        state_d = StDead;
                        cnt_d   = DeadLoad;
                    end
                end
                StHi: begin
                    if (!raw_i) begin
                        state_d = StDead;
                        cnt_d   = DeadLoad;
                    end
                end
                StDead: begin
                    // raw activity inside the interval is ignored; only the final cycle decides
                    if (cnt_q == '0) begin
                        state_d = raw_i ? StHi : StLo;
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
                default: begin
                    state_d = StOff;
                    cnt_d   = '0;
                end
            endcase
        end
        hi_d = (state_d == StHi);
        lo_d = (state_d == StLo);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StOff;
            cnt_q   <= '0;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/pwm_3l_modulator.sv
// Three-level (two-cell, phase-shifted carrier) PWM modulator.
//   clk_i        : clock, rising edge
//   rst_i        : synchronous active-high reset, priority over enable_i
//   enable_i     : run enable; 0 drives all gates low via OFF
//   duty_i       : modulation reference (unsigned)
//   carrier0_i   : 0-degree triangular carrier, cell 1
//   carrier180_i : 180-degree triangular carrier, cell 2
//   gate1_hi_o / gate1_lo_o : cell 1 gate pair
//   gate2_hi_o / gate2_lo_o : cell 2 gate pair
// Optional build macro PWM_DUTY_SHADOW_EN: duty_q reloads only at the carrier0 valley
// (carrier0_i == 0); otherwise duty_q follows duty_i every cycle.
module pwm_3l_modulator
    import pwm_3l_modulator_pkg::*;
#(
    parameter int unsigned Width      = DefaultWidth,
    parameter int unsigned DeadCycles = DefaultDeadCycles
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic [Width-1:0] duty_i,
    input  logic [Width-1:0] carrier0_i,
    input  logic [Width-1:0] carrier180_i,
    output logic             gate1_hi_o,
    output logic             gate1_lo_o,
    output logic             gate2_hi_o,
    output logic             gate2_lo_o
);

    logic [Width-1:0] duty_q, duty_d;
    logic             raw0;
    logic             raw180;

    always_comb begin
`ifdef PWM_DUTY_SHADOW_EN
        // period-aligned update: take the new reference only at the carrier0 valley
        duty_d = (carrier0_i == '0) ? duty_i : duty_q;
`else
        duty_d = duty_i;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            duty_q <= '0;
        end else begin
            duty_q <= duty_d;
        end
    end

    assign raw0   = (duty_q > carrier0_i);
    assign raw180 = (duty_q > carrier180_i);

    pwm_deadtime_leg #(
        .DeadCycles (DeadCycles)
    ) u_leg1 (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .enable_i (enable_i),
        .raw_i    (raw0),
        .hi_o     (gate1_hi_o),
        .lo_o     (gate1_lo_o)
    );

    pwm_deadtime_leg #(
        .DeadCycles (DeadCycles)
    ) u_leg2 (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .enable_i (enable_i),
        .raw_i    (raw180),
        .hi_o     (gate2_hi_o),
        .lo_o     (gate2_lo_o)
    );

endmodule
